inst_cache: RTL

Direct-mapped, read-only instruction cache that answers the fetch stage's instruction-memory read port (`inst_mem_read_addr` / `inst_mem_read_enable`) and refills from a backing memory over a request/response handshake. It sits between the IF stage and the backing instruction memory. On a hit it returns the instruction one cycle after the address is sampled. On a miss it raises a combinational stall that holds the PC while it fetches the whole line.

---
 rtl/inst_cache_pkg.sv | 30 +++
 rtl/inst_cache_array.sv | 59 +++++
 rtl/inst_cache.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/inst_cache_pkg.sv
// +--------------------------------------------------------------------+
// | inst_cache_pkg : shared FSM encoding and address-split widths       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package inst_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2
  } state_t;

  function automatic int calc_offset_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int calc_index_w(input int lines);
    return $clog2(lines);
  endfunction

  // Two byte-offset bits sit below the word offset.
  function automatic int calc_tag_w(input int lines, input int words_per_line);
    return 32 - calc_index_w(lines) - calc_offset_w(words_per_line) - 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_cache_array.sv
// +--------------------------------------------------------------------+
// | inst_cache_array : data/tag storage, registered data read port      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module inst_cache_array #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int INDEX_W        = 4,
  parameter int OFFSET_W       = 2,
  parameter int TAG_W          = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_rd_en,
  input  logic [INDEX_W-1:0]  i_rd_index,
  input  logic [OFFSET_W-1:0] i_rd_offset,
  output logic [31:0]         o_rd_data,
  output logic [TAG_W-1:0]    o_rd_tag,
  input  logic                i_wr_en,
  input  logic [INDEX_W-1:0]  i_wr_index,
  input  logic [OFFSET_W-1:0] i_wr_offset,
  input  logic [31:0]         i_wr_data,
  input  logic                i_tag_wr_en,
  input  logic [TAG_W-1:0]    i_tag_wr_data
);

  localparam int DEPTH = LINES * WORDS_PER_LINE;

  logic [31:0]      r_data_mem [DEPTH];
  logic [TAG_W-1:0] r_tag_mem  [LINES];
  logic [31:0]      r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_data_mem[{i_wr_index, i_wr_offset}] <= i_wr_data;
    end
    if (i_tag_wr_en) begin
      r_tag_mem[i_wr_index] <= i_tag_wr_data;
    end
  end

  // The data port is the cache's output register, so it resets to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_data_mem[{i_rd_index, i_rd_offset}];
    end
  end

  // Tag lookup is combinational so the hit decision lands in the sample cycle.
  assign o_rd_tag  = r_tag_mem[i_rd_index];
  assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/inst_cache.sv
// +--------------------------------------------------------------------+
// | inst_cache : direct-mapped read-only instruction cache with         |
// |              line refill over a request/response handshake          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] inst_mem_read_addr,
  input  logic        inst_mem_read_enable,
  input  logic        invalidate,
  output logic [31:0] inst_mem_read_data,
  output logic        inst_mem_read_valid,
  output logic        IF_mem_stall,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int OFFSET_W = calc_offset_w(WORDS_PER_LINE);
  localparam int INDEX_W  = calc_index_w(LINES);
  localparam int TAG_W    = calc_tag_w(LINES, WORDS_PER_LINE);
  localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(WORDS_PER_LINE - 1);

  state_t              r_state;
  logic [OFFSET_W-1:0] r_beat;
  logic [INDEX_W-1:0]  r_fill_index;
  logic [TAG_W-1:0]    r_fill_tag;
  logic                r_req_valid;
  logic                r_read_valid;
  logic [LINES-1:0]    r_valid;

  logic [OFFSET_W-1:0] w_offset;
  logic [INDEX_W-1:0]  w_index;
  logic [TAG_W-1:0]    w_tag;
  logic [TAG_W-1:0]    w_stored_tag;
  logic                w_hit;
  logic                w_wr_en;
  logic                w_fill_last;
  logic                w_unused_addr_lsb;

  assign w_offset          = inst_mem_read_addr[2 +: OFFSET_W];
  assign w_index           = inst_mem_read_addr[OFFSET_W+2 +: INDEX_W];
  assign w_tag             = inst_mem_read_addr[31 -: TAG_W];
  assign w_unused_addr_lsb = ^inst_mem_read_addr[1:0];

  // A fetch sampled alongside invalidate is forced to miss.
  assign w_hit = (r_state == ST_IDLE) && inst_mem_read_enable && r_valid[w_index] &&
                 (w_stored_tag == w_tag) && !invalidate;

  assign w_wr_en     = (r_state == ST_FILL) && mem_resp_valid;
  assign w_fill_last = w_wr_en && (r_beat == LAST_BEAT);

  assign IF_mem_stall        = (r_state != ST_IDLE) || (inst_mem_read_enable && !w_hit);
  assign mem_req_valid       = r_req_valid;
  assign mem_req_addr        = {r_fill_tag, r_fill_index, {(OFFSET_W + 2){1'b0}}};
  assign inst_mem_read_valid = r_read_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_beat       <= '0;
      r_fill_index <= '0;
      r_fill_tag   <= '0;
      r_req_valid  <= 1'b0;
      r_read_valid <= 1'b0;
    end else begin
      r_read_valid <= w_hit;
      case (r_state)
        ST_IDLE: begin
          if (inst_mem_read_enable && !w_hit) begin
            r_fill_index <= w_index;
            r_fill_tag   <= w_tag;
            r_req_valid  <= 1'b1;
            r_state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            r_req_valid <= 1'b0;
            r_beat      <= '0;
            r_state     <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (mem_resp_valid) begin
            if (r_beat == LAST_BEAT) begin
              r_beat  <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Clear-all happens first so a fill finishing on the same edge keeps its line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
    end else begin
      if (invalidate) begin
        r_valid <= '0;
      end
      if (w_fill_last) begin
        r_valid[r_fill_index] <= 1'b1;
      end
    end
  end

  inst_cache_array #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .INDEX_W        (INDEX_W),
    .OFFSET_W       (OFFSET_W),
    .TAG_W          (TAG_W)
  ) u_array (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_rd_en        (w_hit),
    .i_rd_index     (w_index),
    .i_rd_offset    (w_offset),
    .o_rd_data      (inst_mem_read_data),
    .o_rd_tag       (w_stored_tag),
    .i_wr_en        (w_wr_en),
    .i_wr_index     (r_fill_index),
    .i_wr_offset    (r_beat),
    .i_wr_data      (mem_resp_data),
    .i_tag_wr_en    (w_fill_last),
    .i_tag_wr_data  (r_fill_tag)
  );

endmodule

`default_nettype wire
